// File: rtl/ones_count_pkg.sv
// Shared types and helpers for the ones_count_acc frame popcount accumulator.
// The ONES_COUNT_SAT_EN build option is consumed by ones_count_acc, not here.
package ones_count_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // All-ones source pattern; sliced down to the accumulator width for saturation.
    localparam int SAT_MAX_W = 64;
    localparam logic [SAT_MAX_W-1:0] SAT_PATTERN = '1;

    function automatic int pc_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/ones_count_acc_full_adder.sv
// Single-bit full adder cell used to build the popcount carry-save chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/ones_count_acc.sv
// Per-frame ones counter: popcount each beat, accumulate to in_last, present on valid/ready.
// Define ONES_COUNT_SAT_EN to saturate the total on overflow instead of wrapping.
//
// state | meaning
// IDLE  | no frame in progress, accumulator treated as 0
// ACCUM | frame in progress, acc/ovf hold the partial total
// HOLD  | frame result presented on out_count/out_ovf
module ones_count_acc
    import ones_count_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_count,
    output logic             out_ovf
);

    localparam int PW = pc_width(WIDTH);
    localparam logic [ACC_W-1:0] SAT_VAL = SAT_PATTERN[ACC_W-1:0];

    state_t state, state_next;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [PW-1:0]    pc;
    logic             beat;
    logic             in_frame;
    logic [ACC_W:0]   sum;
    logic             ovf_new;
    logic [ACC_W-1:0] result;

    // Carry-save chain: each stage folds one input bit into a (sum, carry) vector pair.
    // Carries out of the top bit carry weight 2^PW and are safely dropped since pc <= WIDTH.
    for (genvar i = 0; i < WIDTH; i++) begin : g_csa
        logic [PW-1:0] s_in;
        logic [PW-1:0] c_in;
        logic [PW-1:0] s;
        logic [PW-1:0] cy;
        logic [PW-1:0] c;
        logic          unused_top;

        if (i == 0) begin : g_first
            assign s_in = '0;
            assign c_in = '0;
        end else begin : g_next
            assign s_in = g_csa[i-1].s;
            assign c_in = g_csa[i-1].c;
        end

        for (genvar k = 0; k < PW; k++) begin : g_bit
            full_adder u_fa (
                .a     (s_in[k]),
                .b     (c_in[k]),
                .c     ((k == 0) ? in_data[i] : 1'b0),
                .sum   (s[k]),
                .carry (cy[k])
            );
        end

        if (PW == 1) begin : g_c_narrow
            assign c = '0;
        end else begin : g_c_wide
            assign c = {cy[PW-2:0], 1'b0};
        end
        assign unused_top = cy[PW-1];
    end

    // Resolve the final carry-save pair with a ripple of the same cells.
    for (genvar k = 0; k < PW; k++) begin : g_rca
        logic ci;
        logic co;

        if (k == 0) begin : g_lsb
            assign ci = 1'b0;
        end else begin : g_upper
            assign ci = g_rca[k-1].co;
        end

        full_adder u_fa (
            .a     (g_csa[WIDTH-1].s[k]),
            .b     (g_csa[WIDTH-1].c[k]),
            .c     (ci),
            .sum   (pc[k]),
            .carry (co)
        );
    end

    logic unused_rca_top;
    assign unused_rca_top = g_rca[PW-1].co;

    assign beat     = in_valid & in_ready;
    assign in_frame = (state == ACCUM);

    always_comb begin
        sum     = {1'b0, (in_frame ? acc : {ACC_W{1'b0}})}
                + {{(ACC_W + 1 - PW){1'b0}}, pc};
        ovf_new = sum[ACC_W] | (in_frame & ovf);
`ifdef ONES_COUNT_SAT_EN
        result  = ovf_new ? SAT_VAL : sum[ACC_W-1:0];
`else
        result  = sum[ACC_W-1:0];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, ACCUM: begin
                if (beat) begin
                    state_next = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (beat) begin
                        state_next = in_last ? HOLD : ACCUM;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == HOLD);
        in_ready  = (state != HOLD) | out_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            ovf       <= 1'b0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (beat) begin
            if (in_last) begin
                out_count <= result;
                out_ovf   <= ovf_new;
                acc       <= '0;
                ovf       <= 1'b0;
            end else begin
                acc <= result;
                ovf <= ovf_new;
            end
        end
    end

endmodule

// File: tb/tb_ones_count_acc.sv
// Scoreboard bench for ones_count_acc: a 16-bit and a 4-bit accumulator instance share one stream.
// Expected totals follow ONES_COUNT_SAT_EN when it is defined for the build.
module tb_ones_count_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_last;
    logic [7:0]  in_data;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, ovf_a;
    logic [15:0] cnt_a;
    logic        in_ready_b, out_valid_b, ovf_b;
    logic [3:0]  cnt_b;

    int total = 0;
    int bad = 0;
    int frame_sum = 0;
    bit rdy_rand = 0;
    logic [16:0] qa[$];
    logic [16:0] qb[$];

    always #5 clk = ~clk;

    ones_count_acc #(.WIDTH(8), .ACC_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_count(cnt_a), .out_ovf(ovf_a)
    );

    ones_count_acc #(.WIDTH(8), .ACC_W(4)) dut_w4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_count(cnt_b), .out_ovf(ovf_b)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: frame total from plain bit counts, then wrap or clamp to the result width.
    function automatic logic [16:0] expect_frame(input int tot, input int w);
        int maxv;
        bit o;
        int c;
        maxv = (1 << w) - 1;
        o = (tot > maxv);
`ifdef ONES_COUNT_SAT_EN
        c = o ? maxv : tot;
`else
        c = tot % (maxv + 1);
`endif
        return {o, 16'(c)};
    endfunction

    task automatic model_accept(input logic [7:0] d, input logic l);
        frame_sum += $countones(d);
        if (l) begin
            qa.push_back(expect_frame(frame_sum, 16));
            qb.push_back(expect_frame(frame_sum, 4));
            frame_sum = 0;
        end
    endtask

    // Call at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [7:0] d, input logic l);
        bit done;
        done = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int n = 0; n < 1000 && !done; n++) begin
            @(negedge clk);
            if (in_ready_a) begin
                done = 1;
                model_accept(d, l);
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=not_accepted required=accepted data=%0h", d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("in_ready_rule_a", in_ready_a, !out_valid_a || out_ready);
                chk("in_ready_rule_b", in_ready_b, !out_valid_b || out_ready);
                if (out_valid_a && out_ready) begin
                    if (qa.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_a actual=count %0d required=no_output", cnt_a);
                    end else begin
                        e = qa.pop_front();
                        chk("count_a", cnt_a, e[15:0]);
                        chk("ovf_a", ovf_a, e[16]);
                    end
                end
                if (out_valid_b && out_ready) begin
                    if (qb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_b actual=count %0d required=no_output", cnt_b);
                    end else begin
                        e = qb.pop_front();
                        chk("count_w4", cnt_b, e[3:0]);
                        chk("ovf_w4", ovf_b, e[16]);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        logic [7:0] d;
        logic       l;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        out_ready = 1'b1;

        #12;
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_out_count", cnt_a, 0);
        chk("rst_out_ovf", ovf_a, 0);
        chk("rst_in_ready", in_ready_a, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(8'hFF, 0);
        send(8'h0F, 0);
        send(8'h01, 1);
        chk("latency_valid", out_valid_a, 1);
        send(8'hA5, 1);
        send(8'h00, 1);
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        send(8'hA5, 1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready_a, 0);
            chk("bp_hold_count", cnt_a, 4);
            chk("bp_hold_valid", out_valid_a, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'h03, 1);
        chk("concurrent_valid", out_valid_a, 1);

        send(8'hFF, 0);
        send(8'hFF, 1);
        send(8'hFF, 0);
        send(8'hFF, 0);
        send(8'h00, 0);
        send(8'h01, 1);
        send(8'hFF, 0);
        send(8'h0F, 0);
        send(8'h07, 1);

        send(8'hFF, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_frame_valid", out_valid_a, 0);
        chk("rst_mid_frame_ready", in_ready_a, 1);
        frame_sum = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(8'h01, 1);

        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(8'hA5, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", out_valid_a, 0);
        chk("rst_async_count", cnt_a, 0);
        chk("rst_async_ovf", ovf_b, 0);
        qa.delete();
        qb.delete();
        frame_sum = 0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        rdy_rand = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
            d = 8'($urandom);
            l = ($urandom_range(0, 3) == 0);
            send(d, l);
        end
        d = 8'($urandom);
        send(d, 1);
        rdy_rand = 0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("drain_a", qa.size(), 0);
        chk("drain_w4", qb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
